// File: rtl/regfile_scoreboard.sv
// Register file with INIT zero-sweep, write-through bypass and a busy-bit scoreboard.
module regfile_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wb_valid,
  input  logic [$clog2(NREGS)-1:0]       wb_rd,
  input  logic [XLEN-1:0]                wb_data,
  input  logic                           issue_valid,
  input  logic [$clog2(NREGS)-1:0]       issue_rd,
  input  logic                           flush,
  input  logic [NREAD*$clog2(NREGS)-1:0] rd_idx,
  output logic [NREAD*XLEN-1:0]          rd_data,
  output logic [NREAD-1:0]               rd_busy,
  output logic                           ready
);

  localparam int unsigned IDXW = $clog2(NREGS);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] sweep_q, sweep_d;
  logic            sweep_we;
  logic            run;
  logic            wb_en;
  logic            issue_en;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  // State register and sweep counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next-state logic: sweep one register per cycle, leave INIT after the last index
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    sweep_we = 1'b0;
    case (state_q)
      S_INIT: begin
        sweep_we = 1'b1;
        sweep_d  = sweep_q + IDXW'(1);
        if (sweep_q == IDXW'(NREGS - 1)) begin
          state_d = S_RUN;
          sweep_d = '0;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Reset is applied combinationally to the visible outputs so they are quiet while it is held
  assign run      = (state_q == S_RUN) && !reset;
  assign ready    = run;
  assign wb_en    = run && wb_valid && (wb_rd != '0);
  assign issue_en = run && issue_valid && (issue_rd != '0);

  // Storage has no reset; contents become defined through the sweep
  always_ff @(posedge clock) begin
    if (sweep_we && !reset) begin
      regs[sweep_q] <= '0;
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Scoreboard next value: flush beats everything, issue set beats writeback clear
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        if (wb_en) busy_d[wb_rd] = 1'b0;
        if (issue_en) busy_d[issue_rd] = 1'b1;
      end
    end
  end

  // Scoreboard register
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Independent combinational read ports with same-cycle writeback bypass
  for (genvar p = 0; p < int'(NREAD); p++) begin : g_rd
    logic [IDXW-1:0] idx;
    logic            byp;
    assign idx = rd_idx[p*IDXW +: IDXW];
    assign byp = wb_en && (idx == wb_rd);
    assign rd_data[p*XLEN +: XLEN] = (!run || idx == '0) ? '0 :
                                     byp ? wb_data : regs[idx];
    assign rd_busy[p] = run && !byp && busy_q[idx];
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers; power of two, >= 2.
REQ-003 Parameter NREAD, default 2, number of read ports; >= 1.
REQ-004 Localparam IDXW = $clog2(NREGS), register index width.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 wb_valid  input  1  writeback request this cycle.
REQ-008 wb_rd  input  IDXW  writeback destination index.
REQ-009 wb_data  input  XLEN  writeback value.
REQ-010 issue_valid  input  1  an instruction with a destination register issues this cycle.
REQ-011 issue_rd  input  IDXW  destination index of the issuing instruction.
REQ-012 flush  input  1  clear all busy bits (pipeline squash).
REQ-013 rd_idx  input  NREAD*IDXW  packed read indices; port p occupies bits [p*IDXW +: IDXW].
REQ-014 rd_data  output  NREAD*XLEN  packed read data; port p occupies bits [p*XLEN +: XLEN].
REQ-015 rd_busy  output  NREAD  per-port busy flag for the indexed register.
REQ-016 ready  output  1  high when initialisation is complete and the block accepts traffic.

Function
REQ-017 The block SHALL implement a two-state FSM: INIT and RUN.
REQ-018 In INIT the block SHALL write 0 to one register per cycle through a sweep counter, starting at index 0 and ending at NREGS-1.
REQ-019 INIT SHALL last exactly NREGS cycles; on the edge that writes index NREGS-1, the FSM SHALL move to RUN.
REQ-020 ready SHALL be 0 in INIT and 1 in RUN.
REQ-021 In INIT the block SHALL ignore wb_valid, issue_valid and flush, and every rd_data port SHALL return 0 with rd_busy 0.
REQ-022 In RUN, when wb_valid=1 and wb_rd!=0, the block SHALL write wb_data to register wb_rd on the clock edge.
REQ-023 Register 0 SHALL always read as 0, SHALL never be written, and SHALL never be busy.
REQ-024 Reads SHALL be combinational: rd_data[p] = Regs[rd_idx[p]], with no added latency.
REQ-025 Write-through bypass: in RUN, when wb_valid=1, wb_rd!=0 and rd_idx[p]==wb_rd, rd_data[p] SHALL equal wb_data in the same cycle.
REQ-026 Scoreboard set: in RUN, issue_valid=1 with issue_rd!=0 SHALL set busy[issue_rd] on the edge.
REQ-027 Scoreboard clear: in RUN, wb_valid=1 with wb_rd!=0 SHALL clear busy[wb_rd] on the edge.
REQ-028 When set and clear target the same index in the same cycle, set SHALL win and the register SHALL remain busy.
REQ-029 rd_busy[p] SHALL be busy[rd_idx[p]] and SHALL be 0 when the same-cycle bypass of REQ-025 applies.
REQ-030 flush=1 in RUN SHALL clear all busy bits on the edge, taking priority over a simultaneous issue set; a simultaneous writeback SHALL still update data.
REQ-031 All read ports SHALL be independent; identical indices on several ports SHALL return identical data and busy values.

Reset
REQ-032 reset=1 at any edge SHALL force the FSM to INIT, the sweep counter to 0 and all busy bits to 0.
REQ-033 While reset is high, ready SHALL be 0, rd_data SHALL be 0 and rd_busy SHALL be 0.
REQ-034 Reset asserted in RUN or mid-INIT SHALL restart the full NREGS-cycle sweep after it is released.
REQ-035 Register contents SHALL be defined only through the INIT sweep; no register is assumed cleared by reset alone.

Verification
REQ-036 Release reset with defaults -> ready=0 for exactly 32 cycles, then 1; all 32 registers read 0.
REQ-037 RUN: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF with rd_idx[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF combinationally; next cycle with wb_valid=0 -> still 0xDEADBEEF.
REQ-038 Write wb_rd=0 with wb_data=0x1234 -> register 0 reads 0; issue_rd=0 -> rd_busy stays 0.
REQ-039 issue_rd=7 -> rd_busy for index 7 =1 next cycle; later wb_rd=7 -> busy=0 the cycle after; same-cycle issue_rd=7 and wb_rd=7 -> busy stays 1.
REQ-040 Set busy on registers 3, 9 and 12, then flush=1 together with issue_rd=4 -> all four read not busy next cycle.
REQ-041 Assert reset on sweep cycle 10 of INIT, then release -> ready low for a full 32 further cycles; with NREGS=64, NREAD=4, XLEN=64 -> 64-cycle INIT, and all four ports bypass independently.
